// File: rtl/rd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rd_arb_pkg
// Description : Shared types and sizing helpers for the rd_arbiter block.
//               state_t       - access FSM states (IDLE, READ, RESP)
//               idx_w()       - bits needed to index n items (minimum 1)
//               RD_HOLD_W_DEF - hold-counter width for the default RD_HOLD
// Revision    : 1.0  initial release
// ============================================================================
package rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  // A single item still needs a one-bit index so that the vectors stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RD_HOLD_DEF   = 2;
  localparam int RD_HOLD_W_DEF = idx_w(RD_HOLD_DEF);

endpackage : rd_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Selects the first set request
//               at or after the pointer, wrapping at NREQ.
// Ports       : req   in   NREQ  request vector
//               ptr   in   IW    priority pointer (highest priority index)
//               gnt   out  NREQ  one-hot grant (zero when nothing requested)
//               idx   out  IW    index of the granted requester
//               valid out  1     at least one request present
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import rd_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  int w_pos;

  // Scan from the farthest offset back toward the pointer so that the last
  // hit written is the closest one at or after ptr.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = |req;
    w_pos = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_pos = (int'(ptr) + k) % NREQ;
      if (req[w_pos]) begin
        idx = IW'(w_pos);
      end
    end
    if (valid) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rd_arbiter
// Description : Shares one memory read port between NREQ requesters using a
//               round-robin grant. Each access holds mem_rd high for RD_HOLD
//               cycles with a stable address, then returns the memory data
//               with a one-cycle one-hot ack to the granted requester.
// Ports       : clk        in   1        clock, rising edge
//               rst        in   1        synchronous reset, active low
//               ce         in   1        chip enable; gates new grants
//               req        in   NREQ     level requests, held until ack
//               req_addr   in   NREQ*AW  packed request addresses
//               ack        out  NREQ     one-hot data-ready pulse
//               rdata      out  DW       read data, valid with ack
//               busy       out  1        access in progress
//               mem_ce     out  1        registered chip enable to memory
//               mem_rd     out  1        memory read strobe
//               mem_addr   out  AW       memory address
//               mem_rdata  in   DW       memory data, valid after last mem_rd
// Options     : RD_ARBITER_SVA_EN - compiles embedded protocol assertions.
// Revision    : 1.0  initial release
// ============================================================================
module rd_arbiter
  import rd_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int RD_HOLD = RD_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic               mem_ce,
  output logic               mem_rd,
  output logic [AW-1:0]      mem_addr,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int IW        = idx_w(NREQ);
  localparam int RD_HOLD_W = idx_w(RD_HOLD);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [RD_HOLD_W-1:0]   r_cnt;
  logic [IW-1:0]          r_grant;
  logic [NREQ-1:0]        r_gnt_oh;
  logic [IW-1:0]          r_ptr;
  logic [DW-1:0]          r_rdata;
  logic                   r_mem_ce;
  logic [AW-1:0]          r_mem_addr;

  logic [NREQ-1:0]        w_gnt;
  logic [IW-1:0]          w_idx;
  logic                   w_valid;
  logic                   w_last;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req   (req),
    .ptr   (r_ptr),
    .gnt   (w_gnt),
    .idx   (w_idx),
    .valid (w_valid)
  );

  assign w_last = (r_cnt == RD_HOLD_W'(RD_HOLD - 1));

  // Next state and outputs. rdata bypasses the register during RESP so the
  // data is visible in the same cycle as ack; otherwise it holds the last
  // captured value.
  always_comb begin
    w_next_state = r_state;
    busy         = (r_state != IDLE);
    mem_rd       = 1'b0;
    ack          = '0;
    rdata        = r_rdata;
    case (r_state)
      IDLE: begin
        if (ce && w_valid) begin
          w_next_state = READ;
        end
      end
      READ: begin
        mem_rd = 1'b1;
        if (w_last) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        ack          = r_gnt_oh;
        rdata        = mem_rdata;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_gnt_oh   <= '0;
      r_ptr      <= '0;
      r_rdata    <= '0;
      r_mem_ce   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state  <= w_next_state;
      // Memory stays enabled for the whole strobe even if ce falls mid-access,
      // so an accepted read is never cut off at the memory.
      r_mem_ce <= ce | (w_next_state == READ);
      case (r_state)
        IDLE: begin
          if (ce && w_valid) begin
            r_grant    <= w_idx;
            r_gnt_oh   <= w_gnt;
            r_mem_addr <= req_addr[w_idx*AW +: AW];
            r_cnt      <= '0;
          end
        end
        READ: begin
          if (!w_last) begin
            r_cnt <= r_cnt + RD_HOLD_W'(1);
          end
        end
        RESP: begin
          r_rdata <= mem_rdata;
          r_ptr   <= (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_ce   = r_mem_ce;
  assign mem_addr = r_mem_addr;

`ifdef RD_ARBITER_SVA_EN
  a_rd_hold: assert property (@(posedge clk) disable iff (!rst)
    $rose(mem_rd) |-> mem_rd [*RD_HOLD] ##1 !mem_rd);

  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(ack));

  a_rd_ce: assert property (@(posedge clk) disable iff (!rst)
    mem_rd |-> mem_ce);

  // With a single-cycle strobe there is nothing left to hold stable.
  generate
    if (RD_HOLD > 1) begin : g_addr_stable
      a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        $rose(mem_rd) |=> $stable(mem_addr) [*RD_HOLD-1]);
    end
  endgenerate
`else
  // Assertions not compiled in this build.
`endif

endmodule : rd_arbiter
`default_nettype wire
